// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the MIPS fetch-stage next-PC controller:
// reset/exception defaults, FSM encodings, redirect sources and target helpers.
package pc_sequencer_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

    localparam logic [1:0] ST_BOOT  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_JR     = 3'd3,
        SRC_EXC    = 3'd4
    } redirect_src_e;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] offset);
        return pc4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump, jr and exception
// sources resolved by fixed priority, with jr alignment check.
module next_pc_calc
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] i_pc,
    input  logic        i_take_branch,
    input  logic [15:0] i_branch_offset,
    input  logic        i_take_jump,
    input  logic [25:0] i_jump_index,
    input  logic        i_take_jr,
    input  logic [31:0] i_jr_target,
    input  logic        i_exception,
    output logic [31:0] o_target,
    output logic        o_is_redirect,
    output logic        o_is_exc,
    output logic        o_misaligned
);

    logic [31:0]   w_pc4;
    logic          w_jr_unaligned;
    redirect_src_e w_src;

    assign w_pc4          = i_pc + 32'd4;
    assign w_jr_unaligned = |i_jr_target[1:0];

    always_comb begin
        w_src = SRC_SEQ;
        if (i_exception)        w_src = SRC_EXC;
        else if (i_take_jr)     w_src = SRC_JR;
        else if (i_take_jump)   w_src = SRC_JUMP;
        else if (i_take_branch) w_src = SRC_BRANCH;
    end

    always_comb begin
        o_target = w_pc4;
        case (w_src)
            SRC_EXC:    o_target = EXC_VECTOR;
            SRC_JR:     o_target = w_jr_unaligned ? EXC_VECTOR : i_jr_target;
            SRC_JUMP:   o_target = jump_target(w_pc4, i_jump_index);
            SRC_BRANCH: o_target = branch_target(w_pc4, i_branch_offset);
            default:    o_target = w_pc4;
        endcase
    end

    assign o_is_redirect = (w_src != SRC_SEQ);
    assign o_misaligned  = (w_src == SRC_JR) && w_jr_unaligned;
    assign o_is_exc      = (w_src == SRC_EXC) || o_misaligned;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: boot/fetch/stall FSM, PC register, one-entry
// redirect buffer and the redirect/misaligned pulses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_BOOT  | one cycle after reset, no fetch request
//   ST_FETCH | fetch_valid high unless stall is asserted this cycle
//   ST_STALL | pipeline frozen, fetch withdrawn; leave when stall drops
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        fetch_valid,
    output logic [31:0] pc,
    input  logic        take_branch,
    input  logic [15:0] branch_offset,
    input  logic        take_jump,
    input  logic [25:0] jump_index,
    input  logic        take_jr,
    input  logic [31:0] jr_target,
    input  logic        exception,
    output logic        redirect,
    output logic        misaligned
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pending_valid;
    logic [31:0] r_pending_target;
    logic        r_pending_is_exc;
    logic        r_redirect;
    logic        r_misaligned;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_target;
    logic        w_is_redirect;
    logic        w_is_exc;
    logic        w_misaligned;
    logic        w_advance;
    logic        w_exc_now;

    next_pc_calc #(
        .EXC_VECTOR(EXC_VECTOR)
    ) u_next_pc_calc (
        .i_pc            (r_pc),
        .i_take_branch   (take_branch),
        .i_branch_offset (branch_offset),
        .i_take_jump     (take_jump),
        .i_jump_index    (jump_index),
        .i_take_jr       (take_jr),
        .i_jr_target     (jr_target),
        .i_exception     (exception),
        .o_target        (w_target),
        .o_is_redirect   (w_is_redirect),
        .o_is_exc        (w_is_exc),
        .o_misaligned    (w_misaligned)
    );

    assign fetch_valid = (r_state == ST_FETCH) && !stall;
    assign w_advance   = fetch_valid && imem_ready && !stall;
    // Exceptions during BOOT are ignored entirely, including for buffering.
    assign w_exc_now   = exception && (r_state != ST_BOOT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: if (stall) w_state_nxt = ST_STALL;
            ST_STALL: if (!stall) w_state_nxt = ST_FETCH;
            default:  w_state_nxt = ST_BOOT;
        endcase
        if (w_exc_now) w_state_nxt = ST_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_BOOT;
            r_pc             <= RESET_PC;
            r_pending_valid  <= 1'b0;
            r_pending_target <= 32'd0;
            r_pending_is_exc <= 1'b0;
            r_redirect       <= 1'b0;
            r_misaligned     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_redirect   <= 1'b0;
            r_misaligned <= 1'b0;
            if (w_exc_now) begin
                r_pc             <= EXC_VECTOR;
                r_pending_valid  <= 1'b0;
                r_pending_is_exc <= 1'b0;
                r_redirect       <= 1'b1;
            end else if (w_advance) begin
                r_pending_valid  <= 1'b0;
                r_pending_is_exc <= 1'b0;
                if (w_is_redirect) begin
                    r_pc         <= w_target;
                    r_redirect   <= 1'b1;
                    r_misaligned <= w_misaligned;
                end else if (r_pending_valid) begin
                    r_pc         <= r_pending_target;
                    r_redirect   <= 1'b1;
                    r_misaligned <= r_pending_is_exc;
                end else begin
                    r_pc <= w_target;
                end
            end else if (w_is_redirect && !exception) begin
                // Only a misaligned jr reaches here as is_exc; it may displace an entry.
                if (w_is_exc || !r_pending_valid) begin
                    r_pending_valid  <= 1'b1;
                    r_pending_target <= w_target;
                    r_pending_is_exc <= w_is_exc;
                end
            end
        end
    end

    assign pc         = r_pc;
    assign redirect   = r_redirect;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with an expected-value scoreboard.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        take_branch;
    logic [15:0] branch_offset;
    logic        take_jump;
    logic [25:0] jump_index;
    logic        take_jr;
    logic [31:0] jr_target;
    logic        exception;
    logic        redirect;
    logic        misaligned;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .take_branch   (take_branch),
        .branch_offset (branch_offset),
        .take_jump     (take_jump),
        .jump_index    (jump_index),
        .take_jr       (take_jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .redirect      (redirect),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        rd;
        logic        mis;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rdy;
        logic        tb;
        logic [15:0] off;
        logic        tj;
        logic [25:0] idx;
        logic        tjr;
        logic [31:0] jrt;
        logic        exc;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rst, input logic stl, input logic rdy,
                                input logic tb, input logic [15:0] off,
                                input logic tj, input logic [25:0] idx,
                                input logic tjr, input logic [31:0] jrt,
                                input logic exc, input logic [31:0] epc,
                                input logic efv, input logic erd, input logic emis);
        vec_t v;
        v.rst = rst; v.stall = stl; v.rdy = rdy; v.tb = tb; v.off = off;
        v.tj = tj; v.idx = idx; v.tjr = tjr; v.jrt = jrt; v.exc = exc;
        v.e.pc = epc; v.e.fv = efv; v.e.rd = erd; v.e.mis = emis;
        return v;
    endfunction

    function automatic vec_t seq(input logic [31:0] epc);
        return mk(0,0,1, 0,16'h0, 0,26'h0, 0,32'h0, 0, epc,1,0,0);
    endfunction

    task automatic check(input string nm, input exp_t got, input exp_t e);
        n_cmp++;
        if (got.pc !== e.pc || got.fv !== e.fv || got.rd !== e.rd || got.mis !== e.mis) begin
            n_bad++;
            $display("FAIL %s: got pc=%h fv=%b redirect=%b misaligned=%b, want pc=%h fv=%b redirect=%b misaligned=%b",
                     nm, got.pc, got.fv, got.rd, got.mis, e.pc, e.fv, e.rd, e.mis);
        end
    endtask

    function automatic exp_t sample();
        exp_t g;
        g.pc = pc; g.fv = fetch_valid; g.rd = redirect; g.mis = misaligned;
        return g;
    endfunction

    task automatic drive_idle();
        stall = 0; imem_ready = 1; take_branch = 0; branch_offset = 0;
        take_jump = 0; jump_index = 0; take_jr = 0; jr_target = 0; exception = 0;
    endtask

    task automatic apply(input vec_t v, input int k);
        exp_t e;
        @(negedge clk);
        reset = v.rst; stall = v.stall; imem_ready = v.rdy;
        take_branch = v.tb; branch_offset = v.off;
        take_jump = v.tj; jump_index = v.idx;
        take_jr = v.tjr; jr_target = v.jrt; exception = v.exc;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d", k), sample(), e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        reset = 1;
        drive_idle();
        imem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        e.pc = 32'hBFC0_0000; e.fv = 0; e.rd = 0; e.mis = 0;
        check("reset_state", sample(), e);

        //          rst stl rdy tb  off      tj  idx         tjr jrt            exc  pc            fv rd mis
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'hBFC0_0000,1,0,0));
        vecs.push_back(seq(32'hBFC0_0004));
        vecs.push_back(seq(32'hBFC0_0008));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 1,32'h0040_0010,0, 32'h0040_0010,1,1,0));
        vecs.push_back(mk(0,0,1, 1,16'hFFFC, 0,26'h0000000, 0,32'h0,        0, 32'h0040_0004,1,1,0));
        vecs.push_back(seq(32'h0040_0008));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 1,32'h1040_0000,0, 32'h1040_0000,1,1,0));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 1,26'h0000100, 0,32'h0,        0, 32'h1000_0400,1,1,0));
        vecs.push_back(seq(32'h1000_0404));
        vecs.push_back(mk(0,0,1, 1,16'h0010, 0,26'h0000000, 1,32'h0040_1000,0, 32'h0040_1000,1,1,0));
        vecs.push_back(mk(0,0,1, 1,16'h0010, 0,26'h0000000, 1,32'h0040_1002,0, 32'h8000_0180,1,1,1));
        vecs.push_back(seq(32'h8000_0184));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 1,32'hFFFF_FFFC,0, 32'hFFFF_FFFC,1,1,0));
        vecs.push_back(seq(32'h0000_0000));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0, 0,16'h0000, 0,26'h0000000, 0,32'h0,    0, 32'h0000_0000,1,0,0));
        vecs.push_back(mk(0,0,0, 1,16'h0004, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0000,1,0,0));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0014,1,1,0));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0014,0,0,0));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 1,26'h0000200, 0,32'h0,        0, 32'h0000_0014,0,0,0));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0014,0,0,0));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0014,1,0,0));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0800,1,1,0));
        vecs.push_back(seq(32'h0000_0804));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h0000_0804,0,0,0));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        1, 32'h8000_0180,0,1,0));
        vecs.push_back(seq(32'h8000_0184));
        vecs.push_back(mk(0,0,0, 0,16'h0000, 0,26'h0000000, 1,32'h0040_0003,0, 32'h8000_0184,1,0,0));
        vecs.push_back(mk(0,0,0, 1,16'h0001, 0,26'h0000000, 0,32'h0,        0, 32'h8000_0184,1,0,0));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h8000_0180,1,1,1));
        vecs.push_back(seq(32'h8000_0184));
        vecs.push_back(mk(0,0,1, 1,16'h0008, 1,26'h0000003, 0,32'h0,        0, 32'h8000_000C,1,1,0));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h8000_000C,0,0,0));
        vecs.push_back(mk(0,1,1, 0,16'h0000, 1,26'h0000040, 0,32'h0,        0, 32'h8000_000C,0,0,0));
        vecs.push_back(mk(1,1,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'hBFC0_0000,0,0,0));
        vecs.push_back(mk(0,0,1, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'hBFC0_0000,1,0,0));
        vecs.push_back(seq(32'hBFC0_0004));
        vecs.push_back(mk(0,0,0, 0,16'h0000, 0,26'h0000000, 0,32'h0,        1, 32'h8000_0180,1,1,0));
        vecs.push_back(mk(0,0,0, 0,16'h0000, 0,26'h0000000, 0,32'h0,        0, 32'h8000_0180,1,0,0));

        for (int k = 0; k < vecs.size(); k++)
            apply(vecs[k], k);

        // Reset-to-first-fetch latency with a bounded wait.
        @(negedge clk);
        reset = 1;
        drive_idle();
        @(negedge clk);
        reset = 0;
        n = 0;
        while (!fetch_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n != 1 || pc !== 32'hBFC0_0000) begin
            n_bad++;
            $display("FAIL first_fetch: got %0d edges pc=%h, want 1 edge pc=bfc00000", n, pc);
        end
        @(posedge clk);
        #1;
        e.pc = 32'hBFC0_0004; e.fv = 1; e.rd = 0; e.mis = 0;
        check("first_step", sample(), e);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
